sram_port_ctrl: RTL and testbench

SRAM_PORT_CTRL -- requirements
Module: sram_port_ctrl

---
 rtl/sram_port_ctrl.sv | 113 +++++++++++
 tb/tb_sram_port_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// sram_port_ctrl : request/response front end for a 1R1W SRAM with a 2-entry
// in-order read response FIFO and a 1-cycle bypass path.   Rev 1.0
// -----------------------------------------------------------------------------
module sram_port_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_mask,
  input  logic [TAG_W-1:0]    req_tag,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic                mem_w_en,
  output logic [ADDR_W-1:0]   mem_w_addr,
  output logic [DATA_W-1:0]   mem_w_data,
  output logic [DATA_W/8-1:0] mem_w_mask,
  output logic                mem_r_en,
  output logic [ADDR_W-1:0]   mem_r_addr,
  input  logic [DATA_W-1:0]   mem_r_data,
  output logic                busy
);

  logic              inflight_q, inflight_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [1:0]        buf_cnt_q, buf_cnt_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] fifo_data_q [2];
  logic [TAG_W-1:0]  fifo_tag_q  [2];

  logic fire, push, pop, buf_nempty;

  assign buf_nempty = (buf_cnt_q != 2'd0);
  // Capacity counts the in-flight read so its data always has a slot to land in.
  assign req_ready  = reset_n && (({1'b0, buf_cnt_q} + {2'b00, inflight_q}) < 3'd2);
  assign fire       = req_valid & req_ready;
  assign mem_w_en   = fire & req_wr & (|req_mask);
  assign mem_r_en   = fire & ~req_wr;
  assign mem_w_addr = req_addr;
  assign mem_w_data = req_wdata;
  assign mem_w_mask = req_mask;
  assign mem_r_addr = req_addr;
  assign busy       = reset_n & (inflight_q | buf_nempty);

  assign pop  = buf_nempty & rsp_ready;
  assign push = inflight_q & (buf_nempty | ~rsp_ready);

  always_comb begin
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_tag   = '0;
    if (reset_n) begin
      if (buf_nempty) begin
        rsp_valid = 1'b1;
        rsp_rdata = fifo_data_q[rd_ptr_q];
        rsp_tag   = fifo_tag_q[rd_ptr_q];
      end else if (inflight_q) begin
        rsp_valid = 1'b1;
        rsp_rdata = mem_r_data;
        rsp_tag   = tag_q;
      end
    end
  end

  always_comb begin
    inflight_d = mem_r_en;
    tag_d      = mem_r_en ? req_tag : tag_q;
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q ^ pop;
    buf_cnt_d  = buf_cnt_q;
    case ({push, pop})
      2'b10:   buf_cnt_d = buf_cnt_q + 2'd1;
      2'b01:   buf_cnt_d = buf_cnt_q - 2'd1;
      default: buf_cnt_d = buf_cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      inflight_q <= 1'b0;
      tag_q      <= '0;
      buf_cnt_q  <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      buf_cnt_q  <= buf_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= mem_r_data;
      fifo_tag_q[wr_ptr_q]  <= tag_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_port_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_sram_port_ctrl : directed self-checking bench with a byte-masked SRAM model.
// -----------------------------------------------------------------------------
module tb_sram_port_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready, req_wr;
  logic [10:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_mask;
  logic [3:0]  req_tag;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [3:0]  rsp_tag;
  logic        mem_w_en, mem_r_en, busy;
  logic [10:0] mem_w_addr, mem_r_addr;
  logic [31:0] mem_w_data, mem_r_data;
  logic [3:0]  mem_w_mask;

  logic [31:0] mem [0:2047];
  int n_chk = 0;
  int n_fail = 0;

  sram_port_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_tag(rsp_tag),
    .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data), .mem_w_mask(mem_w_mask),
    .mem_r_en(mem_r_en), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // SRAM model: masked write, registered read data held until the next read.
  always @(posedge clock) begin
    if (mem_w_en)
      for (int b = 0; b < 4; b++)
        if (mem_w_mask[b]) mem[mem_w_addr][b*8 +: 8] <= mem_w_data[b*8 +: 8];
    if (mem_r_en) mem_r_data <= mem[mem_r_addr];
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic wr, input logic [10:0] a,
                       input logic [31:0] d, input logic [3:0] m, input logic [3:0] t);
    req_valid = v; req_wr = wr; req_addr = a; req_wdata = d; req_mask = m; req_tag = t;
  endtask

  task automatic next_cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; rsp_ready = 1'b1;
    drive(1'b1, 1'b1, 11'h005, 32'hDEADBEEF, 4'hF, 4'h0);
    @(negedge clock);
    chk_eq("rst_req_ready", req_ready, 0);
    chk_eq("rst_mem_w_en", mem_w_en, 0);
    chk_eq("rst_mem_r_en", mem_r_en, 0);
    chk_eq("rst_rsp_valid", rsp_valid, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_rdata_tag", {rsp_rdata, rsp_tag}, 0);
    next_cyc(); next_cyc();
    reset_n = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    next_cyc();

    // Full write then read-after-write, 1-cycle latency
    drive(1'b1, 1'b1, 11'h005, 32'hAABBCCDD, 4'hF, 4'h0);
    @(negedge clock);
    chk_eq("wr_ready", req_ready, 1);
    chk_eq("wr_w_en", mem_w_en, 1);
    chk_eq("wr_r_en", mem_r_en, 0);
    chk_eq("wr_w_data", mem_w_data, 32'hAABBCCDD);
    next_cyc();
    drive(1'b1, 1'b0, 11'h005, '0, 4'hF, 4'd3);
    @(negedge clock);
    chk_eq("rd_r_en", mem_r_en, 1);
    chk_eq("rd_w_en", mem_w_en, 0);
    chk_eq("rd_r_addr", mem_r_addr, 11'h005);
    chk_eq("rd_rsp_early", rsp_valid, 0);
    next_cyc();
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    @(negedge clock);
    chk_eq("raw_valid", rsp_valid, 1);
    chk_eq("raw_rdata", rsp_rdata, 32'hAABBCCDD);
    chk_eq("raw_tag", rsp_tag, 4'd3);
    chk_eq("raw_busy", busy, 1);
    next_cyc();
    @(negedge clock);
    chk_eq("raw_done_valid", rsp_valid, 0);
    chk_eq("raw_done_busy", busy, 0);
    next_cyc();

    // Partial byte-mask write
    drive(1'b1, 1'b1, 11'h005, 32'h11223344, 4'h5, 4'h0);
    next_cyc();
    drive(1'b1, 1'b0, 11'h005, '0, 4'h0, 4'd7);
    next_cyc();
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    @(negedge clock);
    chk_eq("mask_valid", rsp_valid, 1);
    chk_eq("mask_rdata", rsp_rdata, 32'hAA22CC44);
    chk_eq("mask_tag", rsp_tag, 4'd7);
    next_cyc();

    // Backpressure: FIFO fills, then drains in order
    rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 11'h005, '0, '0, 4'd1);
    @(negedge clock);
    chk_eq("bp0_ready", req_ready, 1);
    next_cyc();
    drive(1'b1, 1'b0, 11'h005, '0, '0, 4'd2);
    @(negedge clock);
    chk_eq("bp1_ready", req_ready, 1);
    chk_eq("bp1_valid", rsp_valid, 1);
    chk_eq("bp1_tag", rsp_tag, 4'd1);
    next_cyc();
    drive(1'b1, 1'b0, 11'h005, '0, '0, 4'd9);
    @(negedge clock);
    chk_eq("bp2_ready", req_ready, 0);
    chk_eq("bp2_r_en", mem_r_en, 0);
    chk_eq("bp2_tag", rsp_tag, 4'd1);
    next_cyc();
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    @(negedge clock);
    chk_eq("bp3_ready", req_ready, 0);
    chk_eq("bp3_buf_cnt", dut.buf_cnt_q, 2);
    chk_eq("bp3_tag", rsp_tag, 4'd1);
    next_cyc();
    rsp_ready = 1'b1;
    @(negedge clock);
    chk_eq("dr0_valid", rsp_valid, 1);
    chk_eq("dr0_tag", rsp_tag, 4'd1);
    chk_eq("dr0_rdata", rsp_rdata, 32'hAA22CC44);
    chk_eq("dr0_ready", req_ready, 0);
    next_cyc();
    @(negedge clock);
    chk_eq("dr1_valid", rsp_valid, 1);
    chk_eq("dr1_tag", rsp_tag, 4'd2);
    chk_eq("dr1_ready", req_ready, 1);
    next_cyc();
    @(negedge clock);
    chk_eq("dr2_valid", rsp_valid, 0);
    chk_eq("dr2_busy", busy, 0);
    next_cyc();

    // Streaming reads, one per cycle
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 11'(i), 32'h100 + 32'(i), 4'hF, 4'h0);
      next_cyc();
    end
    for (int i = 0; i < 9; i++) begin
      if (i < 8) drive(1'b1, 1'b0, 11'(i), '0, '0, 4'(i));
      else       drive(1'b0, 1'b0, '0, '0, '0, '0);
      @(negedge clock);
      if (i < 8) chk_eq($sformatf("str%0d_ready", i), req_ready, 1);
      if (i > 0) begin
        chk_eq($sformatf("str%0d_valid", i), rsp_valid, 1);
        chk_eq($sformatf("str%0d_tag", i), rsp_tag, 4'(i - 1));
        chk_eq($sformatf("str%0d_rdata", i), rsp_rdata, 32'h100 + 32'(i - 1));
      end
      next_cyc();
    end
    @(negedge clock);
    chk_eq("str_end_valid", rsp_valid, 0);
    next_cyc();

    // Zero-mask write: accepted, no SRAM write, no response
    drive(1'b1, 1'b1, 11'h003, 32'hFFFFFFFF, 4'h0, 4'h0);
    @(negedge clock);
    chk_eq("m0_w_en", mem_w_en, 0);
    chk_eq("m0_ready", req_ready, 1);
    next_cyc();
    drive(1'b1, 1'b0, 11'h003, '0, '0, 4'd4);
    @(negedge clock);
    chk_eq("m0_no_rsp", rsp_valid, 0);
    next_cyc();
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    @(negedge clock);
    chk_eq("m0_rdata", rsp_rdata, 32'h103);
    chk_eq("m0_tag", rsp_tag, 4'd4);
    next_cyc();

    // Reset while a read is in flight
    drive(1'b1, 1'b0, 11'h001, '0, '0, 4'd5);
    @(negedge clock);
    chk_eq("rr_r_en", mem_r_en, 1);
    next_cyc();
    drive(1'b0, 1'b0, '0, '0, '0, '0);
    reset_n = 1'b0;
    @(negedge clock);
    chk_eq("rr_valid", rsp_valid, 0);
    chk_eq("rr_busy", busy, 0);
    chk_eq("rr_rdata", rsp_rdata, 0);
    next_cyc();
    reset_n = 1'b1;
    @(negedge clock);
    chk_eq("rr_post_valid", rsp_valid, 0);
    chk_eq("rr_post_busy", busy, 0);
    chk_eq("rr_post_ready", req_ready, 1);
    next_cyc();
    @(negedge clock);
    chk_eq("rr_post2_valid", rsp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
